gate_checker: RTL and testbench

Synthesizable stimulus-and-response checker for a 3-input combinational gate under test. It is the hardware counterpart of the gate testbenches in the COA lab set. On `start`, it walks all 8 input combinations on `dut_a/dut_b/dut_c`, waits a programmable settle time, and samples `dut_y`. Each sample is compared against a parameterized truth table, so one instance can self-test the NAND gate on silicon or FPGA and report pass/fail, a mismatch count and the first failing vector.

---
 rtl/gate_checker.sv | 143 ++++++++++++++
 tb/tb_gate_checker.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gate_checker.sv
// Self-test sequencer for a 3-input combinational gate: walks all 8 vectors, compares
// against TRUTH, reports mismatches. Optional macro: GATE_CHECKER_STOP_ON_FAIL_EN.
module gate_checker #(
  parameter logic [7:0]  TRUTH  = 8'h7F,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] fail_vec
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned ERR_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fv_q, fv_d;
  logic [IDX_W-1:0]   fvec_q, fvec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic accept_c, sample_c, mismatch_c, last_c;

  assign accept_c   = start && (state_q != S_RUN);
  assign sample_c   = (state_q == S_RUN) && (cnt_q == '0);
  assign mismatch_c = dut_y != TRUTH[idx_q];

`ifdef GATE_CHECKER_STOP_ON_FAIL_EN
  assign last_c = mismatch_c || (idx_q == IDX_W'(7));
`else
  assign last_c = (idx_q == IDX_W'(7));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (sample_c && last_c) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    fv_d   = fv_q;
    fvec_d = fvec_q;
    busy_d = busy_q;
    done_d = done_q;
    if (accept_c) begin
      idx_d  = '0;
      cnt_d  = SETTLE_LD;
      err_d  = '0;
      fv_d   = 1'b0;
      fvec_d = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (state_q == S_RUN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        if (mismatch_c) begin
          err_d = err_q + ERR_W'(1);
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = idx_q;
          end
        end
        if (last_c) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          cnt_d = SETTLE_LD;
        end
      end
    end
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
      fv_q   <= 1'b0;
      fvec_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      fv_q   <= fv_d;
      fvec_q <= fvec_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  assign dut_a      = idx_q[2];
  assign dut_b      = idx_q[1];
  assign dut_c      = idx_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: a NAND instance (SETTLE=2) and an AND instance (SETTLE=0),
// each driven by a behavioural gate with an injectable per-vector fault mask.
module tb_gate_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [2];
  logic       a [2], b [2], c [2], y [2];
  logic       busy [2], done [2], pass [2], fv [2];
  logic [3:0] errc [2];
  logic [2:0] fvec [2];
  logic [7:0] fmask [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Gates under test: ideal function XOR an injected fault on selected vectors
  assign y[0] = ~(a[0] & b[0] & c[0]) ^ fmask[0][{a[0], b[0], c[0]}];
  assign y[1] =  (a[1] & b[1] & c[1]) ^ fmask[1][{a[1], b[1], c[1]}];

  gate_checker #(.TRUTH(8'h7F), .SETTLE(2)) u_nand (
    .clk(clk), .rst(rst), .start(start[0]),
    .dut_a(a[0]), .dut_b(b[0]), .dut_c(c[0]), .dut_y(y[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
    .fail_valid(fv[0]), .fail_vec(fvec[0])
  );

  gate_checker #(.TRUTH(8'h80), .SETTLE(0)) u_and (
    .clk(clk), .rst(rst), .start(start[1]),
    .dut_a(a[1]), .dut_b(b[1]), .dut_c(c[1]), .dut_y(y[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
    .fail_valid(fv[1]), .fail_vec(fvec[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] abc(input int sel);
    return {a[sel], b[sel], c[sel]};
  endfunction

  task automatic chk_zero(input int sel, input string tag);
    chk({tag, "_busy"}, busy[sel], 0);
    chk({tag, "_done"}, done[sel], 0);
    chk({tag, "_pass"}, pass[sel], 0);
    chk({tag, "_err"},  errc[sel], 0);
    chk({tag, "_fv"},   fv[sel],   0);
    chk({tag, "_fvec"}, fvec[sel], 0);
    chk({tag, "_abc"},  abc(sel),  0);
  endtask

  // One full run with expectations derived from the fault mask
  task automatic run_one(input int sel, input int settle, input logic [7:0] mask,
                         input bit midstart, input string tag);
    int first = 8, pop = 0, lat, exp_err, exp_fin, cyc;
    bit bad_vec = 0, overlap = 0;
    for (int i = 0; i < 8; i++) if (mask[i]) begin
      pop++;
      if (first == 8) first = i;
    end
`ifdef GATE_CHECKER_STOP_ON_FAIL_EN
    lat     = (first < 8) ? (first + 1) * (settle + 1) : 8 * (settle + 1);
    exp_err = (first < 8) ? 1 : 0;
    exp_fin = (first < 8) ? first : 7;
`else
    lat     = 8 * (settle + 1);
    exp_err = pop;
    exp_fin = 7;
`endif
    fmask[sel] = mask;
    start[sel] = 1'b1;
    tick();
    start[sel] = 1'b0;
    chk({tag, "_busy_at_start"}, busy[sel], 1);
    chk({tag, "_cleared_done"},  done[sel], 0);
    chk({tag, "_cleared_err"},   errc[sel], 0);
    chk({tag, "_cleared_fv"},    fv[sel],   0);
    cyc = 0;
    while (!done[sel] && cyc < 300) begin
      if (abc(sel) !== 3'(cyc / (settle + 1))) bad_vec = 1;
      if (busy[sel] !== 1'b1) overlap = 1;
      if (midstart && cyc == 2) start[sel] = 1'b1;
      tick();
      start[sel] = 1'b0;
      cyc++;
    end
    chk({tag, "_vector_walk_ok"}, bad_vec, 0);
    chk({tag, "_busy_throughout"}, overlap, 0);
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_busy_off"}, busy[sel], 0);
    chk({tag, "_err_count"}, errc[sel], exp_err);
    chk({tag, "_fail_valid"}, fv[sel], (first < 8) ? 1 : 0);
    if (first < 8) chk({tag, "_fail_vec"}, fvec[sel], first);
    chk({tag, "_pass"}, pass[sel], (exp_err == 0) ? 1 : 0);
    chk({tag, "_final_abc"}, abc(sel), exp_fin);
    tick();
    tick();
    chk({tag, "_done_hold"}, done[sel], 1);
    chk({tag, "_err_hold"}, errc[sel], exp_err);
  endtask

  initial begin
    int guard;
    logic [7:0] rm;
    rst = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    fmask[0] = 8'h00; fmask[1] = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk_zero(0, "reset_nand");
    chk_zero(1, "reset_and");

    run_one(0, 2, 8'h00, 0, "nand_good");
    run_one(0, 2, 8'h80, 0, "nand_stuck1");
    run_one(0, 2, 8'h7F, 0, "nand_stuck0");
    for (int r = 0; r < 4; r++) begin
      rm = 8'($urandom_range(0, 255));
      run_one(0, 2, rm, 0, "nand_rand");
    end

    run_one(1, 0, 8'h00, 1, "and_good_midstart");
    run_one(1, 0, 8'h00, 0, "and_restart");
    for (int r = 0; r < 4; r++) begin
      rm = 8'($urandom_range(0, 255));
      run_one(1, 0, rm, 1, "and_rand");
    end
    run_one(1, 0, 8'h00, 0, "and_recover");

    // Reset during vector 4
    fmask[0] = 8'h00;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    guard = 0;
    while (abc(0) != 3'd4 && guard < 100) begin
      tick();
      guard++;
    end
    chk("reach_vec4", abc(0), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero(0, "midrun_rst");
    tick();
    chk("midrun_rst_idle", busy[0], 0);
    run_one(0, 2, 8'h00, 0, "after_rst");

    // Start coincident with reset: reset wins
    rst = 1'b1;
    start[0] = 1'b1;
    tick();
    rst = 1'b0;
    start[0] = 1'b0;
    chk_zero(0, "rst_vs_start");
    tick();
    chk("rst_vs_start_idle", busy[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
